// File: rtl/pir_axi_poll_master.sv
// AXI4-Lite read initiator that polls the PIR status register on a fixed tick
// and logs {timestamp, pir_bit} into a single-port sample BRAM.
module pir_axi_poll_master #(
  parameter int C_M00_AXI_DATA_WIDTH = 32,
  parameter int C_M00_AXI_ADDR_WIDTH = 4,
  parameter int C_PIR_REG_ADDR       = 0,
  parameter int C_POLL_DIV           = 1000,
  parameter int C_BRAM_ADDR_WIDTH    = 10
) (
  input  logic                            m00_axi_aclk,
  input  logic                            m00_axi_areset,
  input  logic                            enable,
  output logic [C_M00_AXI_ADDR_WIDTH-1:0] m00_axi_araddr,
  output logic [2:0]                      m00_axi_arprot,
  output logic                            m00_axi_arvalid,
  input  logic                            m00_axi_arready,
  input  logic [C_M00_AXI_DATA_WIDTH-1:0] m00_axi_rdata,
  input  logic [1:0]                      m00_axi_rresp,
  input  logic                            m00_axi_rvalid,
  output logic                            m00_axi_rready,
  output logic                            bram_en,
  output logic                            bram_we,
  output logic [C_BRAM_ADDR_WIDTH-1:0]    bram_addr,
  output logic [C_M00_AXI_DATA_WIDTH-1:0] bram_din,
  output logic [C_BRAM_ADDR_WIDTH-1:0]    sample_count,
  output logic                            wrapped,
  output logic                            resp_err,
  output logic                            busy
);

  localparam int W     = C_M00_AXI_DATA_WIDTH;
  localparam int AW    = C_M00_AXI_ADDR_WIDTH;
  localparam int DIV_W = (C_POLL_DIV > 1) ? $clog2(C_POLL_DIV) : 1;
  localparam logic [AW-1:0]    PIR_ADDR = C_PIR_REG_ADDR[AW-1:0];
  localparam logic [DIV_W-1:0] DIV_TC   = DIV_W'(C_POLL_DIV - 1);

  typedef enum logic [2:0] {S_IDLE, S_WAIT, S_AR, S_R, S_WR} state_t;

  state_t         state, state_nx;
  logic [DIV_W-1:0] div;
  logic           tick;
  logic [W-2:0]   ts, ts_cap;
  logic           pir_bit;
  logic           unused_rdata;

  assign unused_rdata   = ^m00_axi_rdata[W-1:1];
  assign m00_axi_arprot = 3'b000;
  assign tick           = enable && (div == DIV_TC);

  always_ff @(posedge m00_axi_aclk or posedge m00_axi_areset) begin
    if (m00_axi_areset) begin
      div <= '0;
      ts  <= '0;
    end else begin
      div <= (!enable || tick) ? '0 : div + 1'b1;
      if (tick) ts <= ts + 1'b1;
    end
  end

  always_ff @(posedge m00_axi_aclk or posedge m00_axi_areset) begin
    if (m00_axi_areset) state <= S_IDLE;
    else                state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      S_IDLE: if (enable) state_nx = S_WAIT;
      S_WAIT: if (!enable) state_nx = S_IDLE;
              else if (tick) state_nx = S_AR;
      S_AR:   if (m00_axi_arready) state_nx = S_R;
      S_R:    if (m00_axi_rvalid) state_nx = S_WR;
      S_WR:   state_nx = enable ? S_WAIT : S_IDLE;
      default: state_nx = S_IDLE;
    endcase
  end

  // Timestamp is taken as the post-increment value so the first sample logs ts=1.
  always_ff @(posedge m00_axi_aclk or posedge m00_axi_areset) begin
    if (m00_axi_areset) begin
      ts_cap       <= '0;
      pir_bit      <= 1'b0;
      resp_err     <= 1'b0;
      sample_count <= '0;
      wrapped      <= 1'b0;
    end else begin
      if (state == S_WAIT && tick) ts_cap <= ts + 1'b1;
      if (state == S_R && m00_axi_rvalid) begin
        pir_bit <= (m00_axi_rresp == 2'b00) ? m00_axi_rdata[0] : 1'b0;
        if (m00_axi_rresp != 2'b00) resp_err <= 1'b1;
      end
      if (state == S_WR) begin
        sample_count <= sample_count + 1'b1;
        if (&sample_count) wrapped <= 1'b1;
      end
    end
  end

  // Outputs decode straight from state so an async reset clears them at once.
  always_comb begin
    m00_axi_arvalid = 1'b0;
    m00_axi_araddr  = '0;
    m00_axi_rready  = 1'b0;
    bram_en         = 1'b0;
    bram_we         = 1'b0;
    bram_addr       = '0;
    bram_din        = '0;
    busy            = 1'b0;
    case (state)
      S_AR: begin
        m00_axi_arvalid = 1'b1;
        m00_axi_araddr  = PIR_ADDR;
        busy            = 1'b1;
      end
      S_R: begin
        m00_axi_rready = 1'b1;
        busy           = 1'b1;
      end
      S_WR: begin
        bram_en   = 1'b1;
        bram_we   = 1'b1;
        bram_addr = sample_count;
        bram_din  = {ts_cap, pir_bit};
        busy      = 1'b1;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_pir_axi_poll_master.sv
// Directed bench for pir_axi_poll_master: behavioural AXI-Lite slave with
// programmable arready delay / rresp, and a BRAM write logger.
module tb_pir_axi_poll_master;
  localparam int DW = 32;
  localparam int AW = 4;
  localparam int PA = 4;
  localparam int BW = 3;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          enable = 1'b0;
  logic [AW-1:0] araddr;
  logic [2:0]    arprot;
  logic          arvalid, arready;
  logic [DW-1:0] rdata;
  logic [1:0]    rresp;
  logic          rvalid, rready;
  logic          bram_en, bram_we;
  logic [BW-1:0] bram_addr, sample_count;
  logic [DW-1:0] bram_din;
  logic          wrapped, resp_err, busy;

  int vectors = 0;
  int miscompares = 0;

  // slave config / monitor state
  int        ar_wait = 0;
  logic [1:0] resp_cfg = 2'b00;
  logic      pir = 1'b1;
  int        ar_cnt, hs_cnt, wr_cnt, cyc, first_cyc, last_cyc, arv_cycles;
  logic      pend, drop_err, addr_err;
  logic [BW-1:0] last_addr;
  logic [DW-1:0] last_din;
  logic [DW-1:0] mem [8];

  pir_axi_poll_master #(
    .C_M00_AXI_DATA_WIDTH(DW), .C_M00_AXI_ADDR_WIDTH(AW), .C_PIR_REG_ADDR(PA),
    .C_POLL_DIV(8), .C_BRAM_ADDR_WIDTH(BW)
  ) dut (
    .m00_axi_aclk(clk), .m00_axi_areset(rst), .enable(enable),
    .m00_axi_araddr(araddr), .m00_axi_arprot(arprot),
    .m00_axi_arvalid(arvalid), .m00_axi_arready(arready),
    .m00_axi_rdata(rdata), .m00_axi_rresp(rresp),
    .m00_axi_rvalid(rvalid), .m00_axi_rready(rready),
    .bram_en(bram_en), .bram_we(bram_we), .bram_addr(bram_addr), .bram_din(bram_din),
    .sample_count(sample_count), .wrapped(wrapped), .resp_err(resp_err), .busy(busy)
  );

  always #5 clk = ~clk;

  assign arready = arvalid && (ar_cnt >= ar_wait);
  assign rdata   = {31'b0, pir};
  assign rresp   = resp_cfg;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      rvalid <= 1'b0; ar_cnt <= 0; hs_cnt <= 0; wr_cnt <= 0; cyc <= 0;
      first_cyc <= -1; last_cyc <= -1; arv_cycles <= 0;
      pend <= 1'b0; drop_err <= 1'b0; addr_err <= 1'b0;
      last_addr <= '0; last_din <= '0;
    end else begin
      cyc <= cyc + 1;
      if (arvalid) begin
        arv_cycles <= arv_cycles + 1;
        if (araddr !== AW'(PA)) addr_err <= 1'b1;
      end
      if (pend && !arvalid) drop_err <= 1'b1;
      pend <= arvalid && !arready;
      if (arvalid && arready) begin
        hs_cnt <= hs_cnt + 1; ar_cnt <= 0; rvalid <= 1'b1;
      end else if (arvalid) ar_cnt <= ar_cnt + 1;
      if (rvalid && rready) rvalid <= 1'b0;
      if (bram_we) begin
        wr_cnt <= wr_cnt + 1;
        if (wr_cnt == 0) first_cyc <= cyc;
        last_cyc  <= cyc;
        last_addr <= bram_addr;
        last_din  <= bram_din;
        mem[bram_addr] <= bram_din;
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout required completion");
    $fatal(1, "watchdog");
  end

  // Reset is released at a negedge; the first posedge afterwards logs cyc=0.
  task automatic do_reset(input bit en);
    rst = 1'b1; enable = en;
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic wait_wr(input int n, input int budget, output bit ok);
    int k = 0;
    while (wr_cnt < n && k < budget) begin @(negedge clk); k++; end
    ok = (wr_cnt >= n);
  endtask

  task automatic test_reset;
    rst = 1'b1; enable = 1'b0; ar_wait = 0; resp_cfg = 2'b00; pir = 1'b1;
    #1;
    vectors++;
    if ({arvalid, rready, bram_en, bram_we, wrapped, resp_err, busy} !== 7'b0) begin
      miscompares++;
      $display("FAIL reset_ctrl: got %b required 0000000",
               {arvalid, rready, bram_en, bram_we, wrapped, resp_err, busy});
    end
    vectors++;
    if ({araddr, arprot, bram_addr, bram_din, sample_count} !== '0) begin
      miscompares++;
      $display("FAIL reset_data: araddr=%0h arprot=%0h addr=%0h din=%0h cnt=%0h required all 0",
               araddr, arprot, bram_addr, bram_din, sample_count);
    end
  endtask

  task automatic test_basic;
    bit ok;
    resp_cfg = 2'b00; pir = 1'b1; ar_wait = 0;
    do_reset(1'b1);
    wait_wr(1, 40, ok);
    vectors++;
    if (!ok) begin miscompares++; $display("FAIL basic_wr1_timeout: got %0d writes required 1", wr_cnt); end
    // tick consumed at edge 8 (logs cyc 7); AR, R, WR -> write logged at cyc 10
    vectors++;
    if (first_cyc !== 10) begin miscompares++; $display("FAIL basic_latency: got cyc %0d required 10", first_cyc); end
    vectors++;
    if (last_addr !== 3'd0 || last_din !== 32'd3) begin
      miscompares++; $display("FAIL basic_wr1: got addr %0d din %0h required addr 0 din 3", last_addr, last_din);
    end
    wait_wr(2, 40, ok);
    vectors++;
    if (!ok || last_cyc !== 18) begin miscompares++; $display("FAIL basic_period: got cyc %0d required 18", last_cyc); end
    vectors++;
    if (last_addr !== 3'd1 || last_din !== 32'd5 || sample_count !== 3'd2) begin
      miscompares++;
      $display("FAIL basic_wr2: got addr %0d din %0h cnt %0d required addr 1 din 5 cnt 2",
               last_addr, last_din, sample_count);
    end
  endtask

  task automatic test_ar_delay;
    bit ok;
    resp_cfg = 2'b00; pir = 1'b1; ar_wait = 5;
    do_reset(1'b1);
    wait_wr(1, 60, ok);
    vectors++;
    if (!ok || first_cyc !== 15) begin miscompares++; $display("FAIL ardly_latency: got cyc %0d required 15", first_cyc); end
    vectors++;
    if (drop_err !== 1'b0 || addr_err !== 1'b0) begin
      miscompares++; $display("FAIL ardly_stable: got drop %b addr %b required 0 0", drop_err, addr_err);
    end
    vectors++;
    if (hs_cnt !== 1 || wr_cnt !== 1 || arv_cycles !== 6) begin
      miscompares++;
      $display("FAIL ardly_counts: got hs %0d wr %0d arv %0d required 1 1 6", hs_cnt, wr_cnt, arv_cycles);
    end
    vectors++;
    if (last_din !== 32'd3) begin miscompares++; $display("FAIL ardly_din: got %0h required 3", last_din); end
    ar_wait = 0;
  endtask

  task automatic test_resp_err;
    bit ok;
    resp_cfg = 2'b10; pir = 1'b1; ar_wait = 0;
    do_reset(1'b1);
    wait_wr(1, 40, ok);
    vectors++;
    if (!ok || resp_err !== 1'b1 || last_din !== 32'd2) begin
      miscompares++; $display("FAIL slverr_entry: got err %b din %0h required 1 2", resp_err, last_din);
    end
    resp_cfg = 2'b00;
    wait_wr(2, 40, ok);
    vectors++;
    if (!ok || resp_err !== 1'b1 || last_din !== 32'd5 || last_addr !== 3'd1) begin
      miscompares++;
      $display("FAIL slverr_after_ok: got err %b din %0h addr %0d required 1 5 1", resp_err, last_din, last_addr);
    end
    pir = 1'b0;
    wait_wr(3, 40, ok);
    vectors++;
    if (!ok || last_din !== 32'd6) begin miscompares++; $display("FAIL pir_low: got din %0h required 6", last_din); end
  endtask

  task automatic test_wrap;
    bit ok;
    resp_cfg = 2'b00; pir = 1'b1; ar_wait = 0;
    do_reset(1'b1);
    wait_wr(7, 100, ok);
    vectors++;
    if (!ok || wrapped !== 1'b0 || sample_count !== 3'd7) begin
      miscompares++; $display("FAIL wrap_pre: got wrapped %b cnt %0d required 0 7", wrapped, sample_count);
    end
    wait_wr(8, 20, ok);
    vectors++;
    if (!ok || wrapped !== 1'b1 || sample_count !== 3'd0 || mem[7] !== 32'd17) begin
      miscompares++;
      $display("FAIL wrap_8th: got wrapped %b cnt %0d mem7 %0h required 1 0 11", wrapped, sample_count, mem[7]);
    end
    wait_wr(9, 20, ok);
    vectors++;
    if (!ok || sample_count !== 3'd1 || last_addr !== 3'd0 || mem[0] !== 32'd19 || mem[1] !== 32'd5 || wrapped !== 1'b1) begin
      miscompares++;
      $display("FAIL wrap_9th: got cnt %0d addr %0d mem0 %0h mem1 %0h wrapped %b required 1 0 13 5 1",
               sample_count, last_addr, mem[0], mem[1], wrapped);
    end
  endtask

  task automatic test_enable_drop;
    bit ok;
    int k = 0;
    resp_cfg = 2'b00; pir = 1'b1; ar_wait = 0;
    do_reset(1'b1);
    while (!rready && k < 40) begin @(negedge clk); k++; end
    vectors++;
    if (!rready) begin miscompares++; $display("FAIL endrop_reach_r: got rready %b required 1", rready); end
    enable = 1'b0;
    wait_wr(1, 10, ok);
    vectors++;
    if (!ok || last_din !== 32'd3) begin miscompares++; $display("FAIL endrop_write: got din %0h required 3", last_din); end
    repeat (30) @(negedge clk);
    vectors++;
    if (hs_cnt !== 1 || wr_cnt !== 1 || busy !== 1'b0 || arvalid !== 1'b0) begin
      miscompares++;
      $display("FAIL endrop_idle: got hs %0d wr %0d busy %b arvalid %b required 1 1 0 0", hs_cnt, wr_cnt, busy, arvalid);
    end
  endtask

  task automatic test_reset_mid;
    bit ok;
    int k = 0;
    resp_cfg = 2'b10; pir = 1'b1; ar_wait = 0;
    do_reset(1'b1);
    wait_wr(1, 40, ok);
    vectors++;
    if (!ok || resp_err !== 1'b1 || sample_count !== 3'd1) begin
      miscompares++; $display("FAIL rstmid_pre: got err %b cnt %0d required 1 1", resp_err, sample_count);
    end
    ar_wait = 20;
    while (!arvalid && k < 40) begin @(negedge clk); k++; end
    vectors++;
    if (!arvalid) begin miscompares++; $display("FAIL rstmid_ar: got arvalid %b required 1", arvalid); end
    #1 rst = 1'b1;
    #1;
    vectors++;
    if ({arvalid, rready, bram_we, resp_err, busy} !== 5'b0 || sample_count !== 3'd0) begin
      miscompares++;
      $display("FAIL rstmid_async: got arv %b rr %b we %b err %b busy %b cnt %0d required all 0",
               arvalid, rready, bram_we, resp_err, busy, sample_count);
    end
    ar_wait = 0;
  endtask

  initial begin
    test_reset;
    test_basic;
    test_ar_delay;
    test_resp_err;
    test_wrap;
    test_enable_drop;
    test_reset_mid;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
